// File: rtl/usbdev_pkg.sv
// Shared definitions for the USB device always-on suspend/wake sequencer.
// State encodings are fixed because state_o exposes them to debug software.
`timescale 1ns/1ps
package usbdev_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMING  = 3'd1,
    ST_MONITOR = 3'd2,
    ST_WAKING  = 3'd3,
    ST_RELEASE = 3'd4
  } aon_state_e;

  // Bit positions inside wake_cause_o
  localparam int unsigned CauseBusNotIdle = 0;
  localparam int unsigned CauseBusReset   = 1;
  localparam int unsigned CauseSenseLost  = 2;

endpackage

// File: rtl/usbdev_aon_suspend_seq.sv
// Always-on suspend entry / wake handshake sequencer between the USB device IP,
// the wake detector and the power manager. All outputs are registered.
`timescale 1ns/1ps
module usbdev_aon_suspend_seq
  import usbdev_pkg::*;
#(
  parameter int unsigned ArmTimeout = 16,
  parameter int unsigned RelTimeout = 16
) (
  input  logic       clk_aon_i,
  input  logic       rst_aon_ni,
  input  logic       suspend_cmd_aon_i,
  input  logic       abort_aon_i,
  input  logic       core_ready_aon_i,
  input  logic       wake_detect_active_aon_i,
  input  logic       wake_req_aon_i,
  input  logic       bus_not_idle_aon_i,
  input  logic       bus_reset_aon_i,
  input  logic       sense_lost_aon_i,
  output logic       suspend_req_aon_o,
  output logic       wake_ack_aon_o,
  output logic       pwr_wake_req_o,
  output logic [2:0] wake_cause_o,
  output logic       done_o,
  output logic       arm_err_o,
  output logic       rel_err_o,
  output logic [2:0] state_o
);

  if (ArmTimeout < 2 || ArmTimeout > 255) begin : g_arm_timeout_range
    $error("ArmTimeout must be within 2..255");
  end
  if (RelTimeout < 2 || RelTimeout > 255) begin : g_rel_timeout_range
    $error("RelTimeout must be within 2..255");
  end

  // The timeout fires on the edge that would complete the N-th cycle in the state
  localparam logic [7:0] ArmLast = 8'(ArmTimeout - 1);
  localparam logic [7:0] RelLast = 8'(RelTimeout - 1);

  aon_state_e r_state;
  aon_state_e w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_suspend_req;
  logic       r_wake_ack;
  logic       r_pwr_wake_req;
  logic [2:0] r_wake_cause;
  logic       r_done;
  logic       r_arm_err;
  logic       r_rel_err;

  logic w_done_nxt;
  logic w_arm_err_nxt;
  logic w_rel_err_nxt;
  logic w_capture;
  logic w_clear_cause;

  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = 1'b0;
    w_arm_err_nxt = 1'b0;
    w_rel_err_nxt = 1'b0;
    w_capture     = 1'b0;
    w_clear_cause = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (suspend_cmd_aon_i) begin
          w_state_nxt   = ST_ARMING;
          w_clear_cause = 1'b1;
        end
      end
      ST_ARMING: begin
        if (abort_aon_i) begin
          w_state_nxt = ST_RELEASE;
        end else if (wake_detect_active_aon_i) begin
          w_state_nxt = ST_MONITOR;
        end else if (r_cnt == ArmLast) begin
          w_state_nxt   = ST_IDLE;
          w_arm_err_nxt = 1'b1;
        end
      end
      ST_MONITOR: begin
        // Abort outranks a simultaneous wake so the cause stays untouched
        if (abort_aon_i) begin
          w_state_nxt = ST_RELEASE;
        end else if (wake_req_aon_i) begin
          w_state_nxt = ST_WAKING;
          w_capture   = 1'b1;
        end else if (!wake_detect_active_aon_i) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_WAKING: begin
        if (abort_aon_i || core_ready_aon_i) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!wake_detect_active_aon_i) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == RelLast) begin
          w_state_nxt   = ST_IDLE;
          w_rel_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake levels are decoded from the next state so they change on the transition edge
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_suspend_req  <= 1'b0;
      r_wake_ack     <= 1'b0;
      r_pwr_wake_req <= 1'b0;
      r_wake_cause   <= 3'd0;
      r_done         <= 1'b0;
      r_arm_err      <= 1'b0;
      r_rel_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= 8'd0;
      end else if ((r_state == ST_ARMING || r_state == ST_RELEASE) && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_suspend_req  <= (w_state_nxt == ST_ARMING);
      r_wake_ack     <= (w_state_nxt == ST_RELEASE);
      r_pwr_wake_req <= (w_state_nxt == ST_WAKING);
      r_done         <= w_done_nxt;
      r_arm_err      <= w_arm_err_nxt;
      r_rel_err      <= w_rel_err_nxt;
      if (w_clear_cause) begin
        r_wake_cause <= 3'd0;
      end else if (w_capture) begin
        r_wake_cause[CauseSenseLost]  <= sense_lost_aon_i;
        r_wake_cause[CauseBusReset]   <= bus_reset_aon_i;
        r_wake_cause[CauseBusNotIdle] <= bus_not_idle_aon_i;
      end
    end
  end

  assign suspend_req_aon_o = r_suspend_req;
  assign wake_ack_aon_o    = r_wake_ack;
  assign pwr_wake_req_o    = r_pwr_wake_req;
  assign wake_cause_o      = r_wake_cause;
  assign done_o            = r_done;
  assign arm_err_o         = r_arm_err;
  assign rel_err_o         = r_rel_err;
  assign state_o           = r_state;

  ASSERT_KNOWN_OUTPUTS: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
    !$isunknown({suspend_req_aon_o, wake_ack_aon_o, pwr_wake_req_o, wake_cause_o,
                 done_o, arm_err_o, rel_err_o, state_o}));

  ASSERT_REQ_ACK_EXCLUSIVE: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
    !(suspend_req_aon_o && wake_ack_aon_o));

endmodule

// File: doc/usbdev_aon_suspend_seq.md
USBDEV_AON_SUSPEND_SEQ -- requirements
Module: usbdev_aon_suspend_seq

Interface
REQ-001 Parameter: ArmTimeout, 16, max aon cycles in ARMING awaiting detector activation (range 2..255).
REQ-002 Parameter: RelTimeout, 16, max aon cycles in RELEASE awaiting detector deactivation (range 2..255).
REQ-003 clk_aon_i  in  1  always-on clock, ~200 kHz.
REQ-004 rst_aon_ni  in  1  reset; asynchronous, active-low.
REQ-005 suspend_cmd_aon_i  in  1  single-cycle suspend-entry request from IP, already synchronized to aon.
REQ-006 abort_aon_i  in  1  single-cycle software abort, already synchronized.
REQ-007 core_ready_aon_i  in  1  level; core domain powered and IP ready to resume.
REQ-008 wake_detect_active_aon_i  in  1  wake detector state.
REQ-009 wake_req_aon_i  in  1  wake request from detector.
REQ-010 bus_not_idle_aon_i, bus_reset_aon_i, sense_lost_aon_i  in  1 each  detector event flags.
REQ-011 suspend_req_aon_o  out  1  suspend request to detector.
REQ-012 wake_ack_aon_o  out  1  wake acknowledge to detector.
REQ-013 pwr_wake_req_o  out  1  powerup request to power manager.
REQ-014 wake_cause_o  out  3  sticky {sense_lost, bus_reset, bus_not_idle} captured at wake.
REQ-015 done_o, arm_err_o, rel_err_o  out  1 each  single-cycle status pulses.
REQ-016 state_o  out  3  current FSM state encoding, debug.

Function
REQ-017 FSM states SHALL be IDLE, ARMING, MONITOR, WAKING, RELEASE; all outputs registered.
REQ-018 IDLE: suspend_cmd_aon_i=1 -> ARMING next cycle; wake_cause_o cleared to 0 on this transition.
REQ-019 suspend_cmd_aon_i SHALL be ignored in every state other than IDLE.
REQ-020 ARMING: suspend_req_aon_o=1; wake_detect_active_aon_i=1 -> MONITOR; suspend_req_aon_o deasserts on the cycle MONITOR is entered.
REQ-021 ARMING: cycle counter reaching ArmTimeout without activation -> arm_err_o pulse, IDLE.
REQ-022 MONITOR: wake_req_aon_i=1 -> capture three event flags into wake_cause_o, pwr_wake_req_o=1, -> WAKING.
REQ-023 MONITOR: wake_detect_active_aon_i falling without wake_req_aon_i (externally acked) -> IDLE, done_o pulse.
REQ-024 WAKING: pwr_wake_req_o held until core_ready_aon_i=1 -> RELEASE, pwr_wake_req_o drops same edge.
REQ-025 RELEASE: wake_ack_aon_o=1 until wake_detect_active_aon_i=0 -> IDLE, done_o pulse, wake_ack_aon_o drops same edge.
REQ-026 RELEASE: counter reaching RelTimeout -> rel_err_o pulse, IDLE, wake_ack_aon_o dropped.
REQ-027 abort_aon_i in ARMING, MONITOR or WAKING -> RELEASE (wake_cause_o unchanged, pwr_wake_req_o dropped); ignored in IDLE/RELEASE.
REQ-028 abort_aon_i has priority over wake_req_aon_i and timeout in the same cycle.
REQ-029 Counter: 8-bit saturating, cleared on every state entry, increments only in ARMING/RELEASE.
REQ-030 wake_cause_o SHALL hold its value through IDLE until next suspend_cmd_aon_i.
REQ-031 suspend_req_aon_o and wake_ack_aon_o SHALL never be 1 simultaneously.

Reset
REQ-032 On reset: state IDLE, counter 0, all outputs 0; reset mid-sequence abandons handshake with no pulses.

Structure
REQ-033 State enum (3-bit, explicit encodings) and cause bit indices SHALL live in usbdev_pkg.
REQ-034 Single flat module; no sub-modules; parameter ranges checked with static assertions.
REQ-035 ASSERT_KNOWN on all outputs; assertion for REQ-031.

Verification
REQ-036 suspend_cmd pulse, active after 3 cycles, wake_req with bus_reset=1, core_ready after 10 -> cause=3'b010, pwr_wake_req 10 cycles, ack until active=0, done pulse.
REQ-037 suspend_cmd, active never rises -> arm_err pulse at cycle 16, suspend_req low, state IDLE.
REQ-038 MONITOR, abort and wake_req same cycle -> RELEASE, cause=0, pwr_wake_req never asserted.
REQ-039 RELEASE with active stuck 1 -> rel_err pulse after 16 cycles, wake_ack 0.
REQ-040 suspend_cmd during WAKING -> ignored; reset asserted in WAKING -> all outputs 0 immediately.
